// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register and writeback driver: selects ALU or load data, drives the
// register-file write port, exports the WB result to forwarding, counts retired instructions.
module mem_wb_writeback #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              CLK_WB,
  input  logic              RST_WB,
  input  logic              Stall_WB,
  input  logic              Flush_WB,
  input  logic              ValidM,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic [ADDR_W-1:0] WriteRegM,
  input  logic [DATA_W-1:0] ALUOutM,
  input  logic [DATA_W-1:0] ReadDataM,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  output logic              WE3,
  output logic [DATA_W-1:0] ResultW,
  output logic [ADDR_W-1:0] WriteRegW,
  output logic              RegWriteW,
  output logic [CNT_W-1:0]  RetireCount
);

  logic              valid_w;
  logic              reg_write_w_r;
  logic              memto_reg_w;
  logic [ADDR_W-1:0] write_reg_w;
  logic [DATA_W-1:0] alu_out_w;
  logic [DATA_W-1:0] read_data_w;
  logic [CNT_W-1:0]  retire_count;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; the async reset clears all state without waiting for a clock.
  always_ff @(posedge CLK_WB or negedge RST_WB) begin
    if (!RST_WB) begin
      valid_w       <= 1'b0;
      reg_write_w_r <= 1'b0;
      memto_reg_w   <= 1'b0;
      write_reg_w   <= '0;
      alu_out_w     <= '0;
      read_data_w   <= '0;
      retire_count  <= '0;
    end else begin
      // The occupant leaves WB on any non-stalled edge, even when a flush replaces it.
      if (valid_w && !Stall_WB)
        retire_count <= retire_count + CNT_W'(1);

      if (Flush_WB) begin
        valid_w       <= 1'b0;
        reg_write_w_r <= 1'b0;
      end else if (!Stall_WB) begin
        valid_w       <= ValidM;
        reg_write_w_r <= RegWriteM;
        memto_reg_w   <= MemtoRegM;
        write_reg_w   <= WriteRegM;
        alu_out_w     <= ALUOutM;
        read_data_w   <= ReadDataM;
      end
    end
  end

  // Bubbles and $0 never assert a write, so forwarding cannot match on them either.
  assign WE3         = valid_w & reg_write_w_r & (write_reg_w != '0);
  assign ResultW     = memto_reg_w ? read_data_w : alu_out_w;
  assign A3          = write_reg_w;
  assign WD3         = ResultW;
  assign WriteRegW   = write_reg_w;
  assign RegWriteW   = WE3;
  assign RetireCount = retire_count;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Scoreboard bench for mem_wb_writeback: the driver queues hand-computed post-edge
// expectations, a monitor pops one per clock edge and compares.
module tb_mem_wb_writeback;

  typedef struct {
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] cnt;
    logic        data_x;  // A3/WD3 unconstrained (flushed bubble)
  } exp_t;

  logic        CLK_WB = 1'b0;
  logic        RST_WB;
  logic        Stall_WB, Flush_WB, ValidM, RegWriteM, MemtoRegM;
  logic [4:0]  WriteRegM;
  logic [31:0] ALUOutM, ReadDataM;

  logic [4:0]  A3, WriteRegW;
  logic [31:0] WD3, ResultW, RetireCount;
  logic        WE3, RegWriteW;

  logic [4:0]  a3_s, wrw_s;
  logic [31:0] wd3_s, res_s;
  logic        we3_s, rw_s;
  logic [3:0]  cnt_s;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  always #5 CLK_WB = ~CLK_WB;

  mem_wb_writeback dut (
    .CLK_WB(CLK_WB), .RST_WB(RST_WB), .Stall_WB(Stall_WB), .Flush_WB(Flush_WB),
    .ValidM(ValidM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .WriteRegM(WriteRegM), .ALUOutM(ALUOutM), .ReadDataM(ReadDataM),
    .A3(A3), .WD3(WD3), .WE3(WE3), .ResultW(ResultW), .WriteRegW(WriteRegW),
    .RegWriteW(RegWriteW), .RetireCount(RetireCount)
  );

  mem_wb_writeback #(.CNT_W(4)) dut4 (
    .CLK_WB(CLK_WB), .RST_WB(RST_WB), .Stall_WB(Stall_WB), .Flush_WB(Flush_WB),
    .ValidM(ValidM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .WriteRegM(WriteRegM), .ALUOutM(ALUOutM), .ReadDataM(ReadDataM),
    .A3(a3_s), .WD3(wd3_s), .WE3(we3_s), .ResultW(res_s), .WriteRegW(wrw_s),
    .RegWriteW(rw_s), .RetireCount(cnt_s)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic we, input logic [4:0] a3, input logic [31:0] wd,
                              input logic [31:0] cnt, input logic data_x);
    exp_t e;
    e.we = we; e.a3 = a3; e.wd = wd; e.cnt = cnt; e.data_x = data_x;
    return e;
  endfunction

  // Drive one cycle of MEM-side inputs and queue the state expected after the next edge.
  task automatic cyc(input logic v, input logic rw, input logic m2r, input logic [4:0] wr,
                     input logic [31:0] alu, input logic [31:0] rd,
                     input logic st, input logic fl, input exp_t e);
    @(negedge CLK_WB);
    ValidM = v; RegWriteM = rw; MemtoRegM = m2r; WriteRegM = wr;
    ALUOutM = alu; ReadDataM = rd; Stall_WB = st; Flush_WB = fl;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    ValidM = 0; RegWriteM = 0; MemtoRegM = 0; WriteRegM = '0;
    ALUOutM = '0; ReadDataM = '0; Stall_WB = 0; Flush_WB = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".we3"}, 64'(WE3), 64'd0);
    check({tag, ".a3"}, 64'(A3), 64'd0);
    check({tag, ".wd3"}, 64'(WD3), 64'd0);
    check({tag, ".regwritew"}, 64'(RegWriteW), 64'd0);
    check({tag, ".count"}, 64'(RetireCount), 64'd0);
  endtask

  // Monitor: every edge that has a queued expectation is compared shortly after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK_WB);
      #2;
      if (RST_WB === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("we3", 64'(WE3), 64'(e.we));
        check("regwritew", 64'(RegWriteW), 64'(e.we));
        check("count", 64'(RetireCount), 64'(e.cnt));
        if (!e.data_x) begin
          check("a3", 64'(A3), 64'(e.a3));
          check("writeregw", 64'(WriteRegW), 64'(e.a3));
          check("wd3", 64'(WD3), 64'(e.wd));
          check("resultw", 64'(ResultW), 64'(e.wd));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with random inputs: outputs zero with no edge needed.
    RST_WB = 0;
    ValidM = 1; RegWriteM = 1; MemtoRegM = 1'($urandom);
    WriteRegM = 5'($urandom_range(1, 31)); ALUOutM = $urandom; ReadDataM = $urandom;
    Stall_WB = 0; Flush_WB = 0;
    #1 check_zero("rst_async");
    repeat (2) @(posedge CLK_WB);
    #2 check_zero("rst_held");
    @(negedge CLK_WB);
    idle_inputs();
    RST_WB = 1;
    #1 check_zero("rst_release");

    // ALU writeback, then it retires on the following edge.
    cyc(1, 1, 0, 5'd5, 32'h1234, 32'h0, 0, 0, mk(1, 5'd5, 32'h1234, 0, 0));
    cyc(0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 0, mk(0, 5'd0, 32'h0, 1, 0));
    // Load writeback, then the $0 guard (still counted).
    cyc(1, 1, 1, 5'd9, 32'hAAAA, 32'hDEADBEEF, 0, 0, mk(1, 5'd9, 32'hDEADBEEF, 1, 0));
    cyc(1, 1, 1, 5'd0, 32'hAAAA, 32'hDEADBEEF, 0, 0, mk(0, 5'd0, 32'hDEADBEEF, 2, 0));
    cyc(0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 0, mk(0, 5'd0, 32'h0, 3, 0));
    // Stall holds reg 7 / 0x55 for three edges, then stall+flush makes a bubble.
    cyc(1, 1, 0, 5'd7, 32'h55, 32'h0, 0, 0, mk(1, 5'd7, 32'h55, 3, 0));
    for (int i = 0; i < 3; i++)
      cyc(1, 1, 0, 5'd3, 32'h99, 32'h77, 1, 0, mk(1, 5'd7, 32'h55, 3, 0));
    cyc(1, 1, 0, 5'd3, 32'h99, 32'h77, 1, 1, mk(0, 5'd0, 32'h0, 3, 1));
    cyc(0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 0, mk(0, 5'd0, 32'h0, 3, 0));
    cyc(1, 1, 0, 5'd12, 32'hCAFE, 32'h0, 0, 0, mk(1, 5'd12, 32'hCAFE, 3, 0));

    // Async reset pulse between edges while WE3=1.
    @(negedge CLK_WB);
    idle_inputs();
    #1 check("pre_pulse.we3", 64'(WE3), 64'd1);
    RST_WB = 0;
    #1 check_zero("pulse");
    RST_WB = 1;
    #1 check_zero("post_pulse");

    // Wrap: 17 valid stores (RegWrite=0) retire; the 4-bit counter wraps to 1.
    for (int k = 1; k <= 17; k++)
      cyc(1, 0, 0, 5'(k), 32'(k), 32'h0, 0, 0, mk(0, 5'(k), 32'(k), 32'(k - 1), 0));
    cyc(0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 0, mk(0, 5'd0, 32'h0, 17, 0));
    cyc(0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 0, mk(0, 5'd0, 32'h0, 17, 0));
    @(negedge CLK_WB);
    check("wrap.count4", 64'(cnt_s), 64'd1);
    check("scoreboard.drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
